// File: rtl/md_sched_if.sv
// Handshake bundle between the EX/ID pipeline control and the multiply/divide scheduler.
// The pipeline (master) issues operations; the scheduler (slave) reports busy, stall and HI/LO.
interface md_sched_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        cancel;
    logic        id_is_md;
    logic        busy;
    logic        md_stall;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, rs_val, rt_val, cancel, id_is_md,
        input  busy, md_stall, hi, lo
    );

    modport slave (
        input  start, op, rs_val, rt_val, cancel, id_is_md,
        output busy, md_stall, hi, lo
    );
endinterface

// File: rtl/md_sched.sv
// Multi-cycle HI/LO scheduler: owns HI/LO, counts down mult/div latency and
// stalls MD-class instructions in ID while the unit is occupied.
module md_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic      clk,
    input  logic      reset,
    md_sched_if.slave bus
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [1:0]  opLat;
    logic [31:0] aLat;
    logic [31:0] bLat;
    logic [31:0] hiReg;
    logic [31:0] loReg;
    logic        busyReg;

    logic               accept;
    logic signed [63:0] prodS;
    logic        [63:0] prodU;
    logic        [31:0] divSafe;
    logic signed [31:0] quotS;
    logic signed [31:0] remS;
    logic        [31:0] quotU;
    logic        [31:0] remU;
    logic        [63:0] result;

    assign accept = bus.start & ~bus.cancel & ~busyReg & ~(bus.op[2] & bus.op[1]);

    // A zero divisor is replaced so the divider never faults (the write is suppressed anyway);
    // MIN/-1 is replaced by MIN/1, which yields exactly the required quotient MIN and remainder 0.
    always_comb begin
        prodS   = $signed({{32{aLat[31]}}, aLat}) * $signed({{32{bLat[31]}}, bLat});
        prodU   = {32'd0, aLat} * {32'd0, bLat};
        divSafe = bLat;
        if (bLat == 32'd0 || (opLat == 2'd2 && aLat == 32'h8000_0000 && bLat == 32'hFFFF_FFFF))
            divSafe = 32'd1;
        quotS   = $signed(aLat) / $signed(divSafe);
        remS    = $signed(aLat) % $signed(divSafe);
        quotU   = aLat / divSafe;
        remU    = aLat % divSafe;
        result  = 64'd0;
        case (opLat)
            2'd0: result = prodS;
            2'd1: result = prodU;
            2'd2: result = {remS, quotS};
            2'd3: result = {remU, quotU};
            default: result = 64'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            opLat   <= 2'd0;
            aLat    <= 32'd0;
            bLat    <= 32'd0;
            hiReg   <= 32'd0;
            loReg   <= 32'd0;
            busyReg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (!bus.op[2]) begin
                            opLat   <= bus.op[1:0];
                            aLat    <= bus.rs_val;
                            bLat    <= bus.rt_val;
                            cnt     <= bus.op[1] ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                            state   <= RUN;
                            busyReg <= 1'b1;
                        end else if (!bus.op[0]) begin
                            hiReg <= bus.rs_val;
                        end else begin
                            loReg <= bus.rs_val;
                        end
                    end
                end
                RUN: begin
                    if (cnt == 4'd1) begin
                        if (!(opLat[1] && bLat == 32'd0))
                            {hiReg, loReg} <= result;
                        cnt     <= 4'd0;
                        state   <= IDLE;
                        busyReg <= 1'b0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    busyReg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy     = busyReg;
    assign bus.hi       = hiReg;
    assign bus.lo       = loReg;
    assign bus.md_stall = bus.id_is_md & (busyReg | (bus.start & ~bus.cancel & ~bus.op[2]));

endmodule

// File: doc/md_sched.md
# md_sched

Multiply/divide scheduler for the five-stage MIPS pipeline. It accepts one HI/LO-class operation per start pulse from EX, runs it on a multi-cycle countdown, and owns the HI and LO registers. It drives the stall that freezes PC and IF/ID and bubbles ID/EX whenever an MD-class instruction in ID would touch the unit while it is occupied. It also gates issue against exceptions detected in MEM, so a cancelled instruction never alters HI/LO.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (range 1..15)
- DIV_CYCLES, 10, busy cycles for div/divu (range 1..15)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-low; clears all state on a rising edge where reset==0
- start  in  1  EX holds a valid MD-class op this cycle
- op  in  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6/7 no-op
- rs_val  in  32  operand A (dividend / mthi-mtlo source)
- rt_val  in  32  operand B (divisor)
- cancel  in  1  exception or interrupt taken in MEM this cycle; suppresses start
- id_is_md  in  1  ID holds mult/multu/div/divu/mthi/mtlo/mfhi/mflo
- busy  out  1  operation in flight
- md_stall  out  1  freeze PC and IF/ID, flush ID/EX
- hi  out  32  HI register
- lo  out  32  LO register

## Operation
- States: IDLE (busy=0) and RUN (busy=1). A 4-bit down-counter `cnt` holds the cycles remaining.
- Accepted start: start=1, cancel=0, busy=0, op in 0..5. Starts with cancel=1, busy=1, or op 6/7 are ignored with no state change.
- Accepted op 0..3: latch rs_val, rt_val and op. Load cnt with MULT_CYCLES or DIV_CYCLES. Go to RUN.
- Accepted op 4/5: write hi (mthi) or lo (mtlo) from rs_val at that edge. Remain in IDLE.
- RUN: cnt decrements each cycle. On the edge where cnt==1, write the result to {hi,lo}, set cnt=0 and return to IDLE.
- mult: {hi,lo} = signed(A)*signed(B), full 64-bit result.
- multu: {hi,lo} = unsigned 64-bit product.
- div: lo = quotient truncated toward zero; hi = remainder carrying the sign of the dividend.
- Special case 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- divu: unsigned quotient to lo, remainder to hi.
- Divisor==0 (div or divu): hi and lo keep their previous values. The busy duration is unchanged.
- Operands are taken only from the latched copies. rs_val and rt_val may change freely during RUN.
- cancel has no effect on an operation already in RUN; it always completes.
- md_stall = id_is_md & (busy | (start & ~cancel & op<=3)). This output is combinational.

## Timing
- Reset (reset==0 at an edge): hi=0, lo=0, busy=0, cnt=0, state IDLE. This applies mid-operation too; the in-flight result is discarded.
- mult/multu accepted at edge E0: busy=1 from after E0 through E0+MULT_CYCLES. Result is visible and busy=0 after edge E0+MULT_CYCLES.
- div/divu behaves the same with DIV_CYCLES.
- mthi/mtlo: the new value is visible after the accepting edge. busy stays 0 and no stall is generated.
- mfhi/mflo in ID is stalled until busy=0. It then reads the updated hi/lo through the EX-stage result mux, with no extra cycle.
- Back-to-back: a start on the cycle busy falls (IDLE) is accepted.
- Simultaneous completion edge and reset==0: reset wins.

## Test plan
- Reset, then mult with rs_val=0xFFFFFFFD (-3), rt_val=5:
  - busy high for exactly 5 cycles.
  - Then hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- multu with rs_val=0xFFFFFFFF, rt_val=2: after 5 cycles hi=0x00000001, lo=0xFFFFFFFE.
- div with rs_val=0xFFFFFFF9 (-7), rt_val=2:
  - busy for 10 cycles.
  - Then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - A following divu 7/2 gives lo=3, hi=1.
- mthi 0x12345678, then div with rt_val=0:
  - hi=0x12345678 immediately after the mthi edge.
  - After 10 cycles hi is still 0x12345678 and lo is unchanged.
- start=1 with cancel=1 and op=mult: busy stays 0, hi/lo unchanged, md_stall=0.
- Stall and reset behaviour:
  - mult is accepted, and id_is_md=1 (mflo) is held.
  - md_stall=1 on the start cycle and for all 5 busy cycles, then drops to 0.
  - Repeat the sequence and assert reset==0 at cycle 3: busy=0, hi=lo=0 on the next cycle.
